// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetches, decodes IR[31:27] and walks each
// instruction through its T3-T7 micro-steps, driving every datapath strobe.
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int AOPW = 4
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic [31:0]     IR,
    input  logic            CON_FF,
    input  logic            Stop,
    output logic            Run,
    output logic            PCout,
    output logic            ZLowout,
    output logic            MDRout,
    output logic            BAout,
    output logic            Cout,
    output logic            InPortout,
    output logic            R_out,
    output logic            MAR_enable,
    output logic            PC_enable,
    output logic            MDR_enable,
    output logic            IR_enable,
    output logic            Y_enable,
    output logic            ZLowIn,
    output logic            OutPort_enable,
    output logic            R_in,
    output logic            CON_enable,
    output logic            MDR_read,
    output logic            RAM_write,
    output logic            IncPC,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic [AOPW-1:0] ALU_op
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10110);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10111);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    localparam logic [AOPW-1:0] ALU_ADD = AOPW'(0);
    localparam logic [AOPW-1:0] ALU_SUB = AOPW'(1);
    localparam logic [AOPW-1:0] ALU_AND = AOPW'(2);
    localparam logic [AOPW-1:0] ALU_OR  = AOPW'(3);

    state_t         state_q, state_d;
    logic [OPW-1:0] opcode;
    logic           is_alu_r, is_alu_i, is_ld, is_st, is_br, is_in, is_out, is_halt;
    logic           unused_ir_bits;
    state_t         boundary_next;

    assign opcode         = IR[31:32-OPW];
    assign unused_ir_bits = ^IR[31-OPW:0];

    assign is_alu_r = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
    assign is_alu_i = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_br    = (opcode == OP_BR);
    assign is_in    = (opcode == OP_IN);
    assign is_out   = (opcode == OP_OUT);
    assign is_halt  = (opcode == OP_HALT);

    // ALU function for the register and immediate forms; ADD otherwise.
    function automatic logic [AOPW-1:0] alu_sel(input logic [OPW-1:0] op);
        case (op)
            OP_SUB:          alu_sel = ALU_SUB;
            OP_AND, OP_ANDI: alu_sel = ALU_AND;
            OP_OR, OP_ORI:   alu_sel = ALU_OR;
            default:         alu_sel = ALU_ADD;
        endcase
    endfunction

    // Stop only matters on the edge that would otherwise start a new fetch.
    assign boundary_next = Stop ? S_HALT : S_T0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = boundary_next;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = is_halt ? S_HALT : S_T3;
            S_T3:   state_d = (is_alu_r || is_alu_i || is_ld || is_st || is_br) ? S_T4 : boundary_next;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (is_ld || is_st || is_br) ? S_T6 : boundary_next;
            S_T6:   state_d = (is_ld || is_st) ? S_T7 : boundary_next;
            S_T7:   state_d = boundary_next;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) state_q <= S_RST;
        else       state_q <= state_d;
    end

    // Moore decode: outputs follow the present state (and the latched IR) only.
    always_comb begin
        Run            = (state_q != S_HALT);
        PCout          = 1'b0;
        ZLowout        = 1'b0;
        MDRout         = 1'b0;
        BAout          = 1'b0;
        Cout           = 1'b0;
        InPortout      = 1'b0;
        R_out          = 1'b0;
        MAR_enable     = 1'b0;
        PC_enable      = 1'b0;
        MDR_enable     = 1'b0;
        IR_enable      = 1'b0;
        Y_enable       = 1'b0;
        ZLowIn         = 1'b0;
        OutPort_enable = 1'b0;
        R_in           = 1'b0;
        CON_enable     = 1'b0;
        MDR_read       = 1'b0;
        RAM_write      = 1'b0;
        IncPC          = 1'b0;
        Gra            = 1'b0;
        Grb            = 1'b0;
        Grc            = 1'b0;
        ALU_op         = '0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
            end
            S_T1: begin
                ZLowout = 1'b1; PC_enable = 1'b1; MDR_read = 1'b1; MDR_enable = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IR_enable = 1'b1;
            end
            S_T3: begin
                if (is_alu_r || is_alu_i) begin
                    Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
                end else if (is_ld || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; R_out = 1'b1; CON_enable = 1'b1;
                end else if (is_in) begin
                    InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1;
                end else if (is_out) begin
                    Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu_r) begin
                    Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ALU_op = alu_sel(opcode);
                end else if (is_alu_i) begin
                    Cout = 1'b1; ZLowIn = 1'b1; ALU_op = alu_sel(opcode);
                end else if (is_ld || is_st) begin
                    Cout = 1'b1; ZLowIn = 1'b1; ALU_op = ALU_ADD;
                end else if (is_br) begin
                    PCout = 1'b1; Y_enable = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu_r || is_alu_i) begin
                    ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1;
                end else if (is_ld || is_st) begin
                    ZLowout = 1'b1; MAR_enable = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; ZLowIn = 1'b1; ALU_op = ALU_ADD;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    MDR_read = 1'b1; MDR_enable = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1;
                end else if (is_br) begin
                    // Taken-branch PC load is the one strobe allowed to follow a live input.
                    ZLowout = 1'b1; PC_enable = CON_FF;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1;
                end else if (is_st) begin
                    RAM_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer: per-cycle expected strobe
// patterns for every instruction class plus halt, Stop and mid-instruction Clear.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        CON_FF = 1'b0;
    logic        Stop = 1'b0;
    logic        Run, PCout, ZLowout, MDRout, BAout, Cout, InPortout, R_out;
    logic        MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, ZLowIn;
    logic        OutPort_enable, R_in, CON_enable, MDR_read, RAM_write, IncPC;
    logic        Gra, Grb, Grc;
    logic [3:0]  ALU_op;

    control_sequencer #(.OPW(5), .AOPW(4)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .Run(Run), .PCout(PCout), .ZLowout(ZLowout), .MDRout(MDRout), .BAout(BAout),
        .Cout(Cout), .InPortout(InPortout), .R_out(R_out), .MAR_enable(MAR_enable),
        .PC_enable(PC_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable),
        .Y_enable(Y_enable), .ZLowIn(ZLowIn), .OutPort_enable(OutPort_enable),
        .R_in(R_in), .CON_enable(CON_enable), .MDR_read(MDR_read),
        .RAM_write(RAM_write), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .ALU_op(ALU_op)
    );

    always #5 Clock = ~Clock;

    localparam logic [21:0] B_ROUT   = 22'h000001;
    localparam logic [21:0] B_INPORT = 22'h000002;
    localparam logic [21:0] B_COUT   = 22'h000004;
    localparam logic [21:0] B_BAOUT  = 22'h000008;
    localparam logic [21:0] B_MDROUT = 22'h000010;
    localparam logic [21:0] B_ZOUT   = 22'h000020;
    localparam logic [21:0] B_PCOUT  = 22'h000040;
    localparam logic [21:0] B_CONEN  = 22'h000080;
    localparam logic [21:0] B_RIN    = 22'h000100;
    localparam logic [21:0] B_OUTEN  = 22'h000200;
    localparam logic [21:0] B_ZIN    = 22'h000400;
    localparam logic [21:0] B_YEN    = 22'h000800;
    localparam logic [21:0] B_IREN   = 22'h001000;
    localparam logic [21:0] B_MDREN  = 22'h002000;
    localparam logic [21:0] B_PCEN   = 22'h004000;
    localparam logic [21:0] B_MAREN  = 22'h008000;
    localparam logic [21:0] B_INCPC  = 22'h010000;
    localparam logic [21:0] B_RAMWR  = 22'h020000;
    localparam logic [21:0] B_MDRRD  = 22'h040000;
    localparam logic [21:0] B_GRC    = 22'h080000;
    localparam logic [21:0] B_GRB    = 22'h100000;
    localparam logic [21:0] B_GRA    = 22'h200000;

    localparam logic [31:0] I_ANDI = 32'h6918000C;
    localparam logic [31:0] I_ADD  = 32'h1A080000;
    localparam logic [31:0] I_SUB  = 32'h20000000;
    localparam logic [31:0] I_OR   = 32'h30000000;
    localparam logic [31:0] I_ADDI = 32'h60000000;
    localparam logic [31:0] I_ORI  = 32'h70000000;
    localparam logic [31:0] I_LD   = 32'h01100004;
    localparam logic [31:0] I_ST   = 32'h11100004;
    localparam logic [31:0] I_BR   = 32'h90000000;
    localparam logic [31:0] I_IN   = 32'hB0000000;
    localparam logic [31:0] I_OUT  = 32'hB8000000;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;
    localparam logic [31:0] I_UNK  = 32'hF8000000;

    typedef struct packed {
        logic [31:0] ir;
        logic        con;
        logic        stop;
        logic [26:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] cur_ir = 32'h0;
    logic        cur_con = 1'b0;
    logic        cur_stop = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          tbl = 0;
    logic [26:0] obs;

    assign obs = {Run, ALU_op, Gra, Grb, Grc, MDR_read, RAM_write, IncPC,
                  MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, ZLowIn,
                  OutPort_enable, R_in, CON_enable, PCout, ZLowout, MDRout, BAout,
                  Cout, InPortout, R_out};

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got run/alu/strobes=%h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [21:0] s, input logic [3:0] alu = 4'd0, input logic run = 1'b1);
        vecs.push_back('{ir: cur_ir, con: cur_con, stop: cur_stop, exp: {run, alu, s}});
    endtask

    task automatic fetch();
        push(B_PCOUT | B_MAREN | B_INCPC | B_ZIN);
        push(B_ZOUT | B_PCEN | B_MDRRD | B_MDREN);
        push(B_MDROUT | B_IREN);
    endtask

    task automatic alu_r(input logic [3:0] op);
        fetch();
        push(B_GRB | B_ROUT | B_YEN);
        push(B_GRC | B_ROUT | B_ZIN, op);
        push(B_ZOUT | B_GRA | B_RIN);
    endtask

    task automatic alu_i(input logic [3:0] op);
        fetch();
        push(B_GRB | B_ROUT | B_YEN);
        push(B_COUT | B_ZIN, op);
        push(B_ZOUT | B_GRA | B_RIN);
    endtask

    task automatic mem_front();
        fetch();
        push(B_GRB | B_BAOUT | B_YEN);
        push(B_COUT | B_ZIN, 4'd0);
        push(B_ZOUT | B_MAREN);
    endtask

    task automatic br_seq(input logic con);
        cur_con = con;
        fetch();
        push(B_GRA | B_ROUT | B_CONEN);
        push(B_PCOUT | B_YEN);
        push(B_COUT | B_ZIN, 4'd0);
        push(con ? (B_ZOUT | B_PCEN) : B_ZOUT);
    endtask

    // Entered just after a rising edge; each record covers one full cycle.
    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            IR = vecs[i].ir;
            CON_FF = vecs[i].con;
            Stop = vecs[i].stop;
            @(negedge Clock);
            check($sformatf("tbl%0d_vec%0d", tbl, i), obs, vecs[i].exp);
            @(posedge Clock);
            #1;
        end
        vecs.delete();
        tbl++;
    endtask

    task automatic do_clear();
        @(posedge Clock);
        #1 Clear = 1'b1;
        #1 check("clear_async", obs, {1'b1, 4'd0, 22'd0});
        @(posedge Clock);
        #1 Clear = 1'b0;
    endtask

    initial begin
        // Every opcode class in sequence, ending with Stop held through an add.
        do_clear();
        push(22'd0);
        cur_ir = I_ANDI; alu_i(4'd2);
        cur_ir = I_ADD;  alu_r(4'd0); alu_r(4'd0);
        cur_ir = I_SUB;  alu_r(4'd1);
        cur_ir = I_OR;   alu_r(4'd3);
        cur_ir = I_ORI;  alu_i(4'd3);
        cur_ir = I_ADDI; alu_i(4'd0);
        cur_ir = I_LD;   mem_front(); push(B_MDRRD | B_MDREN); push(B_MDROUT | B_GRA | B_RIN);
        cur_ir = I_ST;   mem_front(); push(B_GRA | B_ROUT | B_MDREN); push(B_RAMWR);
        cur_ir = I_BR;   br_seq(1'b1); br_seq(1'b0);
        cur_con = 1'b0;
        cur_ir = I_IN;   fetch(); push(B_INPORT | B_GRA | B_RIN);
        cur_ir = I_OUT;  fetch(); push(B_GRA | B_ROUT | B_OUTEN);
        cur_ir = I_NOP;  fetch(); push(22'd0);
        cur_ir = I_UNK;  fetch(); push(22'd0);
        cur_ir = I_ADD;  cur_stop = 1'b1; alu_r(4'd0);
        for (int k = 0; k < 3; k++) push(22'd0, 4'd0, 1'b0);
        run_vecs();

        // halt opcode: Run low after T2 and held there; Clear brings Run back.
        cur_stop = 1'b0;
        do_clear();
        push(22'd0);
        cur_ir = I_HALT; fetch();
        for (int k = 0; k < 20; k++) push(22'd0, 4'd0, 1'b0);
        run_vecs();

        // Clear in the middle of ld T5 kills the sequence immediately.
        do_clear();
        push(22'd0);
        cur_ir = I_LD; fetch();
        push(B_GRB | B_BAOUT | B_YEN);
        push(B_COUT | B_ZIN, 4'd0);
        run_vecs();
        #2 check("ld_t5_before_clear", obs, {1'b1, 4'd0, B_ZOUT | B_MAREN});
        Clear = 1'b1;
        #1 check("clear_mid_ld", obs, {1'b1, 4'd0, 22'd0});
        @(negedge Clock);
        check("clear_held", obs, {1'b1, 4'd0, 22'd0});
        @(posedge Clock);
        #1 Clear = 1'b0;
        push(22'd0);
        fetch();
        push(B_GRB | B_BAOUT | B_YEN);
        run_vecs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
